// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/bubble control and a sticky conflict flag.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
    parameter int                 NUM_VAL   = 2,
    parameter int                 DATA_W    = 64,
    parameter int                 ICODE_W   = 4,
    parameter int                 STAT_W    = 4,
    parameter int                 REG_W     = 4,
    parameter logic [ICODE_W-1:0] NOP_ICODE = 4'h1,
    parameter logic [STAT_W-1:0]  AOK_STAT  = 4'h1,
    parameter logic [REG_W-1:0]   RNONE     = 4'hF,
    parameter int                 CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      bubble,
    input  logic                      cnt_clr,
    input  logic [STAT_W-1:0]         in_stat,
    input  logic [ICODE_W-1:0]        in_icode,
    input  logic                      in_cnd,
    input  logic [REG_W-1:0]          in_dstE,
    input  logic [REG_W-1:0]          in_dstM,
    input  logic [NUM_VAL*DATA_W-1:0] in_val,
    output logic [STAT_W-1:0]         out_stat,
    output logic [ICODE_W-1:0]        out_icode,
    output logic                      out_cnd,
    output logic [REG_W-1:0]          out_dstE,
    output logic [REG_W-1:0]          out_dstM,
    output logic [NUM_VAL*DATA_W-1:0] out_val,
    output logic                      ctl_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
`endif
);

    typedef struct packed {
        logic [STAT_W-1:0]         stat;
        logic [ICODE_W-1:0]        icode;
        logic                      cnd;
        logic [REG_W-1:0]          dst_e;
        logic [REG_W-1:0]          dst_m;
        logic [NUM_VAL*DATA_W-1:0] val;
    } stage_t;

    // Every field is cleared so a bubble never exposes stale destinations to forwarding.
    localparam stage_t BUBBLE_IMG = '{AOK_STAT, NOP_ICODE, 1'b0, RNONE, RNONE, '0};

    stage_t stage_q, stage_d;
    logic   ctl_err_q, ctl_err_d;

    always_comb begin
        stage_d   = stage_q;
        ctl_err_d = ctl_err_q | (stall & bubble);
        if (bubble) begin
            stage_d = BUBBLE_IMG;
        end else if (!stall) begin
            stage_d = '{in_stat, in_icode, in_cnd, in_dstE, in_dstM, in_val};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q   <= BUBBLE_IMG;
            ctl_err_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            ctl_err_q <= ctl_err_d;
        end
    end

    assign out_stat  = stage_q.stat;
    assign out_icode = stage_q.icode;
    assign out_cnd   = stage_q.cnd;
    assign out_dstE  = stage_q.dst_e;
    assign out_dstM  = stage_q.dst_m;
    assign out_val   = stage_q.val;
    assign ctl_err   = ctl_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Stall only counts when bubble does not override it; counters saturate.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (bubble && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 1'b1;
            if (stall && !bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    logic [1:0] unused_cfg;
    assign unused_cfg = {cnt_clr, CNT_W[0]};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector scoreboard bench for pipe_stage_reg (NUM_VAL=2, DATA_W=64, CNT_W=3).
module tb_pipe_stage_reg;

    localparam int NV    = 2;
    localparam int DW    = 64;
    localparam int CW    = 3;
    localparam int VW    = NV * DW;

    typedef struct packed {
        logic [3:0]    stat;
        logic [3:0]    icode;
        logic          cnd;
        logic [3:0]    dste;
        logic [3:0]    dstm;
        logic [VW-1:0] val;
    } in_t;

    typedef struct packed {
        logic [3:0]    stat;
        logic [3:0]    icode;
        logic          cnd;
        logic [3:0]    dste;
        logic [3:0]    dstm;
        logic [VW-1:0] val;
        logic          err;
        logic [CW-1:0] scnt;
        logic [CW-1:0] bcnt;
    } obs_t;

    localparam int OBS_W = $bits(obs_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic bubble = 1'b0;
    logic cnt_clr = 1'b0;
    logic [3:0] in_stat = '0, in_icode = '0, in_dstE = '0, in_dstM = '0;
    logic in_cnd = 1'b0;
    logic [VW-1:0] in_val = '0;
    logic [3:0] out_stat, out_icode, out_dstE, out_dstM;
    logic out_cnd, ctl_err;
    logic [VW-1:0] out_val;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(.NUM_VAL(NV), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble), .cnt_clr(cnt_clr),
        .in_stat(in_stat), .in_icode(in_icode), .in_cnd(in_cnd),
        .in_dstE(in_dstE), .in_dstM(in_dstM), .in_val(in_val),
        .out_stat(out_stat), .out_icode(out_icode), .out_cnd(out_cnd),
        .out_dstE(out_dstE), .out_dstM(out_dstM), .out_val(out_val),
        .ctl_err(ctl_err)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

`ifndef PIPE_PERF_CNT_EN
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

    // Scoreboard
    logic [OBS_W-1:0] exp_q[$];
    string            name_q[$];
    int               n_cmp  = 0;
    int               n_fail = 0;

    function automatic in_t mk_in(logic [3:0] st, logic [3:0] ic, logic c,
                                  logic [3:0] de, logic [3:0] dm, logic [VW-1:0] v);
        in_t r;
        r = '{st, ic, c, de, dm, v};
        return r;
    endfunction

    function automatic obs_t mk_exp(in_t d, logic e, int sc, int bc);
        obs_t r;
        r = '{d.stat, d.icode, d.cnd, d.dste, d.dstm, d.val, e, CW'(sc), CW'(bc)};
        return r;
    endfunction

    task automatic step(string name, logic r, logic s, logic b, logic clr, in_t d, obs_t e);
        @(negedge clk);
        rst_n    = r;
        stall    = s;
        bubble   = b;
        cnt_clr  = clr;
        in_stat  = d.stat;
        in_icode = d.icode;
        in_cnd   = d.cnd;
        in_dstE  = d.dste;
        in_dstM  = d.dstm;
        in_val   = d.val;
        @(posedge clk);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: registered outputs are settled by the falling edge after the capture edge.
    initial begin
        obs_t  e, a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{out_stat, out_icode, out_cnd, out_dstE, out_dstM, out_val,
                       ctl_err, stall_cnt, bubble_cnt};
`ifndef PIPE_PERF_CNT_EN
                e.scnt = '0;
                e.bcnt = '0;
`endif
                n_cmp++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got stat=%h icode=%h cnd=%b dstE=%h dstM=%h err=%b scnt=%0d bcnt=%0d val=%h | expected stat=%h icode=%h cnd=%b dstE=%h dstM=%h err=%b scnt=%0d bcnt=%0d val=%h",
                             nm, a.stat, a.icode, a.cnd, a.dste, a.dstm, a.err, a.scnt, a.bcnt, a.val,
                             e.stat, e.icode, e.cnd, e.dste, e.dstm, e.err, e.scnt, e.bcnt, e.val);
                end
            end
        end
    end

    initial begin
        in_t img, junk, p_a, p_b, p_c, p_d, p_e, p_f, p_g;
        img  = mk_in(4'h1, 4'h1, 1'b0, 4'hF, 4'hF, '0);
        junk = mk_in(4'h2, 4'h7, 1'b1, 4'h2, 4'h3, {64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000});
        p_a  = mk_in(4'h1, 4'h6, 1'b1, 4'h3, 4'hF, {64'hDEAD, 64'hBEEF});
        p_b  = mk_in(4'h1, 4'h5, 1'b0, 4'h2, 4'h1, {64'h1234, 64'h5678});
        p_c  = mk_in(4'h2, 4'h2, 1'b1, 4'h7, 4'h4, {64'hAA, 64'hBB});
        p_d  = mk_in(4'h1, 4'h3, 1'b0, 4'h0, 4'h9, {64'h1, 64'h2});
        p_e  = mk_in(4'h1, 4'h4, 1'b1, 4'h5, 4'h6, {64'hCAFE, 64'hF00D});
        p_f  = mk_in(4'h3, 4'h6, 1'b0, 4'hA, 4'hB, {64'h7777, 64'h8888});
        p_g  = mk_in(4'h4, 4'h8, 1'b1, 4'hC, 4'hD, {64'h9999, 64'hAAAA});

        step("reset",        0, 0, 0, 0, junk, mk_exp(img, 0, 0, 0));
        step("pass_a",       1, 0, 0, 0, p_a,  mk_exp(p_a, 0, 0, 0));
        step("load_b",       1, 0, 0, 0, p_b,  mk_exp(p_b, 0, 0, 0));
        step("stall_1",      1, 1, 0, 0, p_c,  mk_exp(p_b, 0, 1, 0));
        step("stall_2",      1, 1, 0, 0, p_c,  mk_exp(p_b, 0, 2, 0));
        step("stall_3",      1, 1, 0, 0, p_c,  mk_exp(p_b, 0, 3, 0));
        step("post_stall",   1, 0, 0, 0, p_c,  mk_exp(p_c, 0, 3, 0));
        step("bubble_1",     1, 0, 1, 0, p_d,  mk_exp(img, 0, 3, 1));
        step("bubble_2",     1, 0, 1, 0, p_d,  mk_exp(img, 0, 3, 2));
        step("pass_d",       1, 0, 0, 0, p_d,  mk_exp(p_d, 0, 3, 2));
        step("conflict",     1, 1, 1, 0, p_e,  mk_exp(img, 1, 3, 3));
        step("sticky_e",     1, 0, 0, 0, p_e,  mk_exp(p_e, 1, 3, 3));
        step("sticky_f",     1, 0, 0, 0, p_f,  mk_exp(p_f, 1, 3, 3));
        step("clr_pass",     1, 0, 0, 1, p_g,  mk_exp(p_g, 1, 0, 0));
        for (int i = 1; i <= 9; i++) begin
            step($sformatf("stall_sat_%0d", i), 1, 1, 0, 0, p_a,
                 mk_exp(p_g, 1, (i > 7) ? 7 : i, 0));
        end
        step("clr_in_stall", 1, 1, 0, 1, p_a,  mk_exp(p_g, 1, 0, 0));
        step("stall_again",  1, 1, 0, 0, p_a,  mk_exp(p_g, 1, 1, 0));
        step("rst_conflict", 0, 1, 1, 0, p_b,  mk_exp(img, 0, 0, 0));
        step("pass_post_rst",1, 0, 0, 0, p_b,  mk_exp(p_b, 0, 0, 0));

        @(negedge clk);
        rst_n   = 1'b1;
        stall   = 1'b0;
        bubble  = 1'b0;
        cnt_clr = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
